// File: rtl/tcb_lib_memory.sv
// TCB subordinate memory with byte-enable writes, per-lane read hold and a fixed DLY-stage response pipeline.
// Optional address error checking is enabled by defining TCB_LIB_MEMORY_ERR_EN.
module tcb_lib_memory #(
    parameter int unsigned ABW = 32,
    parameter int unsigned DBW = 32,
    parameter int unsigned SLW = 8,
    parameter int unsigned BEW = DBW/SLW,
    parameter int unsigned DLY = 1,
    parameter int unsigned SIZ = 4096
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           tcb_vld,
    output logic           tcb_rdy,
    input  logic           tcb_wen,
    input  logic [ABW-1:0] tcb_adr,
    input  logic [BEW-1:0] tcb_ben,
    input  logic [DBW-1:0] tcb_wdt,
    output logic [DBW-1:0] tcb_rdt,
    output logic           tcb_err
);

    localparam int unsigned AW  = $clog2(SIZ);
    localparam int unsigned LW  = $clog2(BEW);
    localparam int unsigned WRD = SIZ/BEW;

    logic [DBW-1:0]    mem [WRD];
    logic              trn;
    logic [AW-LW-1:0]  idx;
    logic              adr_err;
    logic [BEW-1:0]    ena_in;
    logic [DBW-1:0]    rdt_in;

    logic [BEW-1:0]    ena_q [DLY];
    logic [DBW-1:0]    rdt_q [DLY];
    logic              err_q [DLY];

    assign trn = tcb_vld & tcb_rdy;
    assign idx = tcb_adr[AW-1:LW];

`ifdef TCB_LIB_MEMORY_ERR_EN
    assign adr_err = (tcb_adr >= ABW'(SIZ)) || ((tcb_adr & ABW'(BEW-1)) != '0);
`else
    // Address wraps modulo SIZ and low bits are ignored, so these bits play no role.
    logic unused_adr;
    assign unused_adr = ^{tcb_adr[ABW-1:AW], tcb_adr[LW-1:0]};
    assign adr_err    = 1'b0;
`endif

    // Lane flags select which bytes of stage 1 take new data; erroring reads force zeros on all lanes.
    always_comb begin
        ena_in = '0;
        rdt_in = mem[idx];
        if (trn && !tcb_wen) begin
            if (adr_err) begin
                ena_in = '1;
                rdt_in = '0;
            end else begin
                ena_in = tcb_ben;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (trn && tcb_wen && !adr_err) begin
            for (int i = 0; i < BEW; i++) begin
                if (tcb_ben[i]) mem[idx][i*SLW +: SLW] <= tcb_wdt[i*SLW +: SLW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tcb_rdy <= 1'b0;
            for (int k = 0; k < DLY; k++) begin
                ena_q[k] <= '0;
                rdt_q[k] <= '0;
                err_q[k] <= 1'b0;
            end
        end else begin
            tcb_rdy  <= 1'b1;
            ena_q[0] <= ena_in;
            err_q[0] <= trn & adr_err;
            for (int i = 0; i < BEW; i++) begin
                if (ena_in[i]) rdt_q[0][i*SLW +: SLW] <= rdt_in[i*SLW +: SLW];
            end
            // Later stages copy a lane only when its flag travelled with it; others hold.
            for (int k = 1; k < DLY; k++) begin
                ena_q[k] <= ena_q[k-1];
                err_q[k] <= err_q[k-1];
                for (int i = 0; i < BEW; i++) begin
                    if (ena_q[k-1][i]) rdt_q[k][i*SLW +: SLW] <= rdt_q[k-1][i*SLW +: SLW];
                end
            end
        end
    end

    assign tcb_rdt = rdt_q[DLY-1];
    assign tcb_err = err_q[DLY-1];

endmodule

// File: tb/tb_tcb_lib_memory.sv
// Bench for tcb_lib_memory: three instances (DLY=1,2,3) share one stimulus stream,
// each with its own expected-response queue and response monitor.
module tb_tcb_lib_memory;

    localparam int NI  = 3;
    localparam int SIZ = 4096;

    logic        clk;
    logic        rst;
    logic        vld;
    logic        wen;
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
    logic        rdy [NI];
    logic [31:0] rdt [NI];
    logic        err [NI];

    int          compared;
    int          mismatched;
    logic [31:0] model_rdt;

`ifdef TCB_LIB_MEMORY_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < NI; g++) begin : gen_dut
        localparam int D = g + 1;
        logic [32:0] exp_q [$];
        logic [31:0] last_rdt;

        tcb_lib_memory #(.DLY(D)) dut (
            .clk     (clk),
            .rst     (rst),
            .tcb_vld (vld),
            .tcb_rdy (rdy[g]),
            .tcb_wen (wen),
            .tcb_adr (adr),
            .tcb_ben (ben),
            .tcb_wdt (wdt),
            .tcb_rdt (rdt[g]),
            .tcb_err (err[g])
        );

        // monitor: a response is due D edges after each observed handshake
        initial begin : mon
            logic [3:0]  due;
            logic [32:0] e;
            due      = '0;
            last_rdt = '0;
            forever begin
                @(posedge clk);
                if (!rst) due = '0;
                else      due = {due[2:0], vld & rdy[g]};
                @(negedge clk);
                if (!rst) begin
                    exp_q.delete();
                    due      = '0;
                    last_rdt = '0;
                    compared++;
                    if (rdy[g] !== 1'b0 || rdt[g] !== 32'h0 || err[g] !== 1'b0) begin
                        mismatched++;
                        $display("FAIL dly%0d in_reset: rdy=%b rdt=%h err=%b, expected rdy=0 rdt=0 err=0",
                                 D, rdy[g], rdt[g], err[g]);
                    end
                end else if (due[D-1]) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL dly%0d unexpected_rsp: rdt=%h err=%b, expected no response", D, rdt[g], err[g]);
                    end else begin
                        e = exp_q.pop_front();
                        if (rdt[g] !== e[31:0] || err[g] !== e[32]) begin
                            mismatched++;
                            $display("FAIL dly%0d rsp: rdt=%h err=%b, expected rdt=%h err=%b",
                                     D, rdt[g], err[g], e[31:0], e[32]);
                        end
                        last_rdt = e[31:0];
                    end
                end else begin
                    compared++;
                    if (rdt[g] !== last_rdt || err[g] !== 1'b0) begin
                        mismatched++;
                        $display("FAIL dly%0d idle_hold: rdt=%h err=%b, expected rdt=%h err=0",
                                 D, rdt[g], err[g], last_rdt);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic push_all(input logic [32:0] v);
        gen_dut[0].exp_q.push_back(v);
        gen_dut[1].exp_q.push_back(v);
        gen_dut[2].exp_q.push_back(v);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d, input logic e);
        vld = 1'b1; wen = 1'b1; adr = a; ben = b; wdt = d;
        push_all({e, model_rdt});
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [3:0] b, input logic [31:0] x, input logic e);
        vld = 1'b1; wen = 1'b0; adr = a; ben = b; wdt = 32'h0;
        push_all({e, x});
        model_rdt = x;
        @(posedge clk); #1;
        vld = 1'b0;
    endtask

    task automatic idle(input int n);
        vld = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_rdy(input string name, input logic x);
        for (int g = 0; g < NI; g++) begin
            compared++;
            if (rdy[g] !== x) begin
                mismatched++;
                $display("FAIL %s[%0d]: rdy=%b, expected %b", name, g, rdy[g], x);
            end
        end
    endtask

    // release reset and confirm ready rises only on the first edge after release
    task automatic reset_cycle(input string name);
        rst = 1'b0;
        model_rdt = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_rdy({name, "_rdy_low"}, 1'b0);
        @(posedge clk); #1;
        chk_rdy({name, "_rdy_high"}, 1'b1);
    endtask

    // stimulus
    initial begin
        compared   = 0;
        mismatched = 0;
        model_rdt  = 32'h0;
        vld = 1'b0; wen = 1'b0; adr = 32'h0; ben = 4'h0; wdt = 32'h0;
        rst = 1'b1;
        #2;
        reset_cycle("reset");

        // full-word write then read back-to-back
        wr(32'h10, 4'hF, 32'h01234567, 1'b0);
        rd(32'h10, 4'hF, 32'h01234567, 1'b0);

        // partial write and lane hold
        wr(32'h20, 4'hF, 32'h11223344, 1'b0);
        wr(32'h20, 4'h2, 32'hAABBCCDD, 1'b0);
        rd(32'h20, 4'hF, 32'h1122CC44, 1'b0);
        rd(32'h20, 4'h1, 32'h1122CC44, 1'b0);
        rd(32'h10, 4'h1, 32'h1122CC67, 1'b0);
        idle(2);

        // preload and back-to-back reads
        wr(32'h100, 4'hF, 32'hA0A1A2A3, 1'b0);
        wr(32'h104, 4'hF, 32'hB0B1B2B3, 1'b0);
        wr(32'h108, 4'hF, 32'hC0C1C2C3, 1'b0);
        wr(32'h10C, 4'hF, 32'hD0D1D2D3, 1'b0);
        rd(32'h100, 4'hF, 32'hA0A1A2A3, 1'b0);
        rd(32'h104, 4'hF, 32'hB0B1B2B3, 1'b0);
        rd(32'h108, 4'hF, 32'hC0C1C2C3, 1'b0);
        rd(32'h10C, 4'hF, 32'hD0D1D2D3, 1'b0);
        idle(5);

        // reset one cycle after a read handshake
        rd(32'h108, 4'hF, 32'hC0C1C2C3, 1'b0);
        @(posedge clk); #1;
        reset_cycle("mid_reset");
        idle(4);
        rd(32'h104, 4'hF, 32'hB0B1B2B3, 1'b0);
        idle(4);

        // error path / address wrap
        wr(32'h0, 4'hF, 32'h0BADF00D, 1'b0);
        wr(SIZ, 4'hF, 32'h5A5A5A5A, ERR_ON);
        rd(32'h0, 4'hF, ERR_ON ? 32'h0BADF00D : 32'h5A5A5A5A, 1'b0);
        rd(32'h11, 4'hF, ERR_ON ? 32'h0 : 32'h01234567, ERR_ON);
        rd(32'h20, 4'hF, 32'h1122CC44, 1'b0);
        idle(6);

        for (int g = 0; g < NI; g++) begin
            compared++;
            if (g == 0 && gen_dut[0].exp_q.size() != 0 ||
                g == 1 && gen_dut[1].exp_q.size() != 0 ||
                g == 2 && gen_dut[2].exp_q.size() != 0) begin
                mismatched++;
                $display("FAIL drain[%0d]: responses still pending, expected none pending", g);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
